// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO drained by a bit-timing FSM, LSB first.
// tx and busy are registered from the next-state decode so the pin never glitches.
module uart_tx_fifo #(
   parameter int DIVISOR = 104,
   parameter int DEPTH   = 16,
   parameter int ADDR_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [7:0]        wr_data,
   output logic              full,
   output logic [ADDR_W:0]   level,
   output logic              busy,
   output logic              overflow,
   output logic              tx
);

   localparam int BC_W = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t              state, state_d;
   logic [BC_W-1:0]     bc, bc_d;
   logic [2:0]          bit_idx, bit_idx_d;
   logic [7:0]          sr, sr_d;
   logic                tx_d;
   logic                bc_last;

   logic [7:0]          mem [DEPTH];
   logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
   logic [ADDR_W:0]     count;
   logic                push, pop;

   assign level = count;
   assign full  = (count == (ADDR_W+1)'(DEPTH));
   assign push  = wr_en && !full;
   assign pop   = (state == IDLE) && (count != '0);

   // Storage is deliberately left out of reset; only pointers and count are cleared.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + (ADDR_W+1)'(1);
            2'b01:   count <= count - (ADDR_W+1)'(1);
            default: count <= count;
         endcase
         // A pop on the same edge does not rescue a write that saw full.
         if (wr_en && full) overflow <= 1'b1;
      end
   end

   assign bc_last = (bc == BC_W'(DIVISOR - 1));

   always_comb begin
      state_d   = state;
      bc_d      = bc;
      bit_idx_d = bit_idx;
      sr_d      = sr;
      case (state)
         IDLE: begin
            if (pop) begin
               sr_d    = mem[rd_ptr];
               bc_d    = '0;
               state_d = START;
            end
         end
         START: begin
            if (bc_last) begin
               bc_d      = '0;
               bit_idx_d = '0;
               state_d   = DATA;
            end else begin
               bc_d = bc + BC_W'(1);
            end
         end
         DATA: begin
            if (bc_last) begin
               sr_d = {1'b0, sr[7:1]};
               bc_d = '0;
               if (bit_idx == 3'd7) state_d = STOP;
               else                 bit_idx_d = bit_idx + 3'd1;
            end else begin
               bc_d = bc + BC_W'(1);
            end
         end
         STOP: begin
            if (bc_last) begin
               bc_d    = '0;
               state_d = IDLE;
            end else begin
               bc_d = bc + BC_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = sr_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         bc      <= '0;
         bit_idx <= '0;
         sr      <= '0;
         tx      <= 1'b1;
         busy    <= 1'b0;
      end else begin
         state   <= state_d;
         bc      <= bc_d;
         bit_idx <= bit_idx_d;
         sr      <= sr_d;
         tx      <= tx_d;
         busy    <= (state_d != IDLE);
      end
   end

endmodule
